score_keeper: RTL and testbench
===============================

// Module: score_keeper
// PURPOSE
//  Parametrised BCD score counter with integrated multiplexed 7-seg display driver for the snake game.
//  Sits between the game FSM (game_state, get_food) and the board display pins.
//  Adds a configurable number of points per food and saturates at the all-9s maximum.
//  Tracks a session high score and scans DIGITS display digits without an external display module.
// PARAMETERS
//  DIGITS      4   number of BCD digits in the score and number of anode lines (1..8)
//  POINTS      1   points added per accepted food event (1..9)
//  SCAN_DIV    17  prescaler width; the display advances one digit every 2**SCAN_DIV clk cycles
//  BLANK_LZ    1   1 = blank leading zeros; digit 0 is always shown
// PORTS
//  clk           in   1          system clock
//  rst           in   1          asynchronous, active-high reset
//  game_state    in   2          game FSM state (encodings in package)
//  get_food      in   1          food-eaten level/pulse from the game logic
//  show_hi       in   1          1 = display the high score instead of the live score
//  score_bcd     out  4*DIGITS   live score, packed BCD, digit 0 = LSB nibble
//  hi_score_bcd  out  4*DIGITS   high score, packed BCD
//  new_record    out  1          sticky flag: the live score exceeded the high score this game
//  an            out  DIGITS     active-low one-hot digit enable
//  seg           out  8          active-low segments {dp,g,f,e,d,c,b,a}
// BEHAVIOUR
//  - Reset (async, rst=1): score, hi score, new_record, food_d, prescaler and digit index all 0;
//    an = ~1 (digit 0 enabled); seg shows '0' with dp off.
//  - Food acceptance: register food_d <= get_food. Accept when get_food & ~food_d & game_state==GS_PLAY.
//    A held get_food level therefore scores once. Food arriving outside GS_PLAY is dropped.
//  - Score update: the registered score changes on the clk edge that samples the accepted rising edge.
//    The adder is a ripple BCD add of POINTS into digit 0 with decimal carry across all digits, in one cycle.
//  - Saturation: if the carry out of the top digit is 1, score <= all digits 9. It never wraps.
//  - Clear: game_state==GS_RESTART -> score <= 0 every cycle it is held, and new_record <= 0.
//    Clear has priority; no food is accepted in that state.
//  - GS_PAUSE / GS_OVER: score frozen.
//  - High score (macro on): combinational BCD compare score > hi.
//    When true, the next edge sets hi <= score and new_record <= 1.
//    hi lags score by one cycle and is never cleared except by rst.
//  - Display: the prescaler free-runs; on wrap, the digit index increments, wrapping DIGITS-1 -> 0.
//    an = ~(1<<idx). The displayed nibble comes from hi when show_hi=1, else from score.
//    show_hi is sampled per cycle, with no glitch protection.
//  - Blanking: with BLANK_LZ=1, a digit idx>0 is blanked (seg=8'hFF) when it and all higher digits are 0.
//  - Decoding: nibbles 0-9 map to standard glyphs; 10-15 (illegal) show '-' (g only). dp is always off.
// CONFIGURATION
//  SCORE_HISCORE_EN defined: high-score register, new_record and show_hi are functional.
//  SCORE_HISCORE_EN undefined: hi_score_bcd=0, new_record=0, show_hi ignored, compare logic removed.
// STRUCTURE
//  score_pkg: GS_PLAY=2'b00, GS_PAUSE=2'b01, GS_RESTART=2'b10, GS_OVER=2'b11.
//  score_pkg also holds the SEG_* glyph constants and SEG_BLANK=8'hFF.
//  Sub-module bcd_digit_add: one digit, inputs a, b, cin; outputs sum, cout.
//  bcd_digit_add is instantiated DIGITS times in a generate loop.
//  The scan/decode logic stays inline.
// TESTING
//  1 rst pulse mid-scan -> all outputs at their reset values immediately, without waiting for clk.
//  2 GS_PLAY, 3 one-cycle get_food pulses -> score_bcd 0x0003; get_food held for 10 cycles -> only +1.
//  3 POINTS=7, score 0x0095, food -> 0x0102 (carry across 2 digits).
//  4 score 0x9998, POINTS=3, food -> 0x9999 saturated; a further food leaves 0x9999.
//  5 hi=0x0002, play to 0x0003 -> new_record=1, hi=0x0003 one cycle later.
//    GS_RESTART -> score 0, new_record 0, hi kept at 0x0003.
//  6 SCAN_DIV=2, score 0x0040, BLANK_LZ=1 -> an cycles 1110,1101,1011,0111 every 4 clk.
//    seg shows '0','4',blank,blank. Food during GS_PAUSE -> score unchanged.

Source files
------------

// File: rtl/score_pkg.sv
// score_pkg: shared types and constants for the snake-game score keeper.
// It holds the game FSM state encodings, the active-low 7-segment glyphs and
// the nibble-to-glyph decoder.
package score_pkg;

  typedef enum logic [1:0] {
    GS_PLAY    = 2'b00,
    GS_PAUSE   = 2'b01,
    GS_RESTART = 2'b10,
    GS_OVER    = 2'b11
  } game_state_e;

  // Active-low segments {dp,g,f,e,d,c,b,a}. dp is always off (1).
  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_DASH  = 8'hBF;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Map a nibble to its glyph. Non-BCD values (10-15) show a dash.
  function automatic logic [7:0] seg_decode(input logic [3:0] nib);
    case (nib)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_DASH;
    endcase
  endfunction

endpackage

// File: rtl/score_keeper_bcd_digit_add.sv
// bcd_digit_add: one decimal digit of a ripple BCD adder.
// It computes a + b + cin and applies the +6 correction when the binary sum exceeds 9.
module bcd_digit_add (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [4:0] raw;

  // Binary add, then fold results above 9 back into a single decimal digit.
  always_comb begin
    raw  = 5'(a) + 5'(b) + 5'(cin);
    sum  = raw[3:0];
    cout = 1'b0;
    if (raw > 5'd9) begin
      sum  = 4'(raw + 5'd6);
      cout = 1'b1;
    end
  end

endmodule

// File: rtl/score_keeper.sv
// score_keeper: BCD score counter with saturation and a multiplexed 7-seg driver.
// Optional macro SCORE_HISCORE_EN adds the session high score, new_record and show_hi.
// Without that macro, hi_score_bcd and new_record are tied to 0 and show_hi is ignored.
module score_keeper
  import score_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int POINTS   = 1,
  parameter int SCAN_DIV = 17,
  parameter int BLANK_LZ = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            game_state,
  input  logic                  get_food,
  input  logic                  show_hi,
  output logic [4*DIGITS-1:0]   score_bcd,
  output logic [4*DIGITS-1:0]   hi_score_bcd,
  output logic                  new_record,
  output logic [DIGITS-1:0]     an,
  output logic [7:0]            seg
);

  localparam int                  IDX_W      = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [3:0]          POINTS_NIB = 4'(POINTS);
  localparam logic [4*DIGITS-1:0] SCORE_MAX  = {DIGITS{4'h9}};

  game_state_e          gs;
  logic                 food_q;
  logic                 accept;
  logic [4*DIGITS-1:0]  score_q, score_d;
  logic [4*DIGITS-1:0]  sum_bcd;
  logic [DIGITS:0]      carry;
  logic [4*DIGITS-1:0]  hi_q;
  logic                 nr_q;
  logic [SCAN_DIV-1:0]  presc_q;
  logic [IDX_W-1:0]     idx_q;
  logic [4*DIGITS-1:0]  disp_val;
  logic [3:0]           nib;
  logic                 blank;

  assign gs     = game_state_e'(game_state);
  assign accept = get_food & ~food_q & (gs == GS_PLAY);

  // Ripple BCD adder: POINTS enters digit 0 and decimal carries run across every digit.
  assign carry[0] = 1'b0;
  for (genvar g = 0; g < DIGITS; g++) begin : g_add
    bcd_digit_add u_add (
      .a    (score_q[4*g +: 4]),
      .b    ((g == 0) ? POINTS_NIB : 4'd0),
      .cin  (carry[g]),
      .sum  (sum_bcd[4*g +: 4]),
      .cout (carry[g+1])
    );
  end

  // Next score: clearing wins, accepted food adds points and saturates at all nines.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    score_d = score_q;
    if (gs == GS_RESTART) begin
      score_d = '0;
    end else if (accept) begin
      score_d = carry[DIGITS] ? SCORE_MAX : sum_bcd;
    end
  end

  // Score and food edge-detect registers.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      score_q <= '0;
      food_q  <= 1'b0;
    end else begin
      score_q <= score_d;
      food_q  <= get_food;
    end
  end

`ifdef SCORE_HISCORE_EN
  logic [4*DIGITS-1:0] hi_d;
  logic                nr_d;

  // High-score tracking: packed BCD with legal digits orders like an unsigned binary value.
  always_comb begin
    hi_d = hi_q;
    nr_d = nr_q;
    if (score_q > hi_q) begin
      hi_d = score_q;
      nr_d = 1'b1;
    end
    if (gs == GS_RESTART) begin
      nr_d = 1'b0;
    end
  end

  // High score and record flag; only rst clears the high score.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q <= '0;
      nr_q <= 1'b0;
    end else begin
      hi_q <= hi_d;
      nr_q <= nr_d;
    end
  end

  assign disp_val = show_hi ? hi_q : score_q;
`else
  logic unused_show_hi;

  assign unused_show_hi = show_hi;
  assign hi_q           = '0;
  assign nr_q           = 1'b0;
  assign disp_val       = score_q;
`endif

  // Scan prescaler and digit index; the index advances each time the prescaler wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
      idx_q   <= '0;
    end else begin
      presc_q <= presc_q + 1'b1;
      if (&presc_q) begin
        idx_q <= (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
      end
    end
  end

  // Pick the scanned nibble and blank it when it is a leading zero.
  always_comb begin
    nib   = disp_val[4*idx_q +: 4];
    blank = (BLANK_LZ != 0) && (idx_q != '0) && ((disp_val >> (4*idx_q)) == '0);
    seg   = blank ? SEG_BLANK : seg_decode(nib);
  end

  assign an           = ~(DIGITS'(1) << idx_q);
  assign score_bcd    = score_q;
  assign hi_score_bcd = hi_q;
  assign new_record   = nr_q;

endmodule

// File: tb/tb_score_keeper.sv
// tb_score_keeper: randomized and directed checks of score_keeper against an
// integer-arithmetic reference model (DIGITS=4, POINTS=3, SCAN_DIV=2, BLANK_LZ=1).
module tb_score_keeper;

  localparam int DIGITS    = 4;
  localparam int POINTS    = 3;
  localparam int SCAN_DIV  = 2;
  localparam int BLANK_LZ  = 1;
  localparam int MAX_SCORE = 9999;
`ifdef SCORE_HISCORE_EN
  localparam bit HI_EN = 1'b1;
`else
  localparam bit HI_EN = 1'b0;
`endif

  localparam logic [1:0] PLAY    = 2'b00;
  localparam logic [1:0] PAUSE   = 2'b01;
  localparam logic [1:0] RESTART = 2'b10;
  localparam logic [1:0] OVER    = 2'b11;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  game_state;
  logic        get_food;
  logic        show_hi;
  logic [15:0] score_bcd;
  logic [15:0] hi_score_bcd;
  logic        new_record;
  logic [3:0]  an;
  logic [7:0]  seg;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int m_score, m_hi, m_cycles;
  bit m_nr, m_food_prev;

  score_keeper #(
    .DIGITS(DIGITS), .POINTS(POINTS), .SCAN_DIV(SCAN_DIV), .BLANK_LZ(BLANK_LZ)
  ) dut (
    .clk(clk), .rst(rst), .game_state(game_state), .get_food(get_food),
    .show_hi(show_hi), .score_bcd(score_bcd), .hi_score_bcd(hi_score_bcd),
    .new_record(new_record), .an(an), .seg(seg)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int x;
    x = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Standard active-high gfedcba patterns, inverted onto the active-low bus with dp off.
  function automatic logic [7:0] glyph(input int d);
    logic [6:0] p;
    case (d)
      0: p = 7'h3F;  1: p = 7'h06;  2: p = 7'h5B;  3: p = 7'h4F;  4: p = 7'h66;
      5: p = 7'h6D;  6: p = 7'h7D;  7: p = 7'h07;  8: p = 7'h7F;  9: p = 7'h6F;
      default: p = 7'h40;
    endcase
    return {1'b1, ~p};
  endfunction

  function automatic int exp_idx();
    return (m_cycles >> SCAN_DIV) % DIGITS;
  endfunction

  function automatic logic [3:0] exp_an();
    return ~(4'(1) << exp_idx());
  endfunction

  function automatic logic [7:0] exp_seg();
    int val, idx, up;
    val = (HI_EN && show_hi) ? m_hi : m_score;
    idx = exp_idx();
    up  = val;
    for (int k = 0; k < idx; k++) up = up / 10;
    if (BLANK_LZ != 0 && idx > 0 && up == 0) return 8'hFF;
    return glyph(up % 10);
  endfunction

  // Advance the model by one clock edge using the inputs presented at that edge.
  task automatic model_edge();
    int  old_score, old_hi;
    bit  acc;
    old_score = m_score;
    old_hi    = m_hi;
    acc = get_food && !m_food_prev && (game_state == PLAY);
    if (game_state == RESTART) m_score = 0;
    else if (acc) m_score = (old_score + POINTS > MAX_SCORE) ? MAX_SCORE : old_score + POINTS;
    if (HI_EN && old_score > old_hi) begin
      m_hi = old_score;
      m_nr = 1'b1;
    end
    if (game_state == RESTART) m_nr = 1'b0;
    m_food_prev = get_food;
    m_cycles++;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic pulse();
    get_food = 1'b1;
    step();
    get_food = 1'b0;
    step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    game_state = PLAY;
    get_food = 1'b0;
    show_hi = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_score = 0; m_hi = 0; m_nr = 1'b0; m_food_prev = 1'b0; m_cycles = 0;
  endtask

  // Asynchronous reset mid-scan clears every output before any clock edge.
  task automatic test_reset();
    do_reset();
    repeat (5) pulse();
    repeat (7) step();
    #2 rst = 1'b1;
    #1;
    checks++; if (score_bcd !== 16'h0000) begin errors++; $display("FAIL rst_score got=%h want=0000", score_bcd); end
    checks++; if (hi_score_bcd !== 16'h0000) begin errors++; $display("FAIL rst_hi got=%h want=0000", hi_score_bcd); end
    checks++; if (new_record !== 1'b0) begin errors++; $display("FAIL rst_new_record got=%b want=0", new_record); end
    checks++; if (an !== 4'b1110) begin errors++; $display("FAIL rst_an got=%b want=1110", an); end
    checks++; if (seg !== 8'hC0) begin errors++; $display("FAIL rst_seg got=%h want=c0", seg); end
    @(negedge clk);
    rst = 1'b0;
    m_score = 0; m_hi = 0; m_nr = 1'b0; m_food_prev = 1'b0; m_cycles = 0;
  endtask

  // Single pulses score once each; a held level scores only once.
  task automatic test_food_edges();
    do_reset();
    repeat (3) pulse();
    checks++; if (score_bcd !== 16'h0009) begin errors++; $display("FAIL pulses3 got=%h want=0009", score_bcd); end
    get_food = 1'b1;
    repeat (10) step();
    get_food = 1'b0;
    step();
    checks++; if (score_bcd !== 16'h0012) begin errors++; $display("FAIL held_level got=%h want=0012", score_bcd); end
    checks++; if (score_bcd !== to_bcd(m_score)) begin errors++; $display("FAIL held_model got=%h want=%h", score_bcd, to_bcd(m_score)); end
  endtask

  // Decimal carry across two digits: 0099 + 3 -> 0102.
  task automatic test_carry();
    repeat (29) pulse();
    checks++; if (score_bcd !== 16'h0099) begin errors++; $display("FAIL carry_pre got=%h want=0099", score_bcd); end
    pulse();
    checks++; if (score_bcd !== 16'h0102) begin errors++; $display("FAIL carry_post got=%h want=0102", score_bcd); end
  endtask

  // Food outside PLAY is dropped.
  task automatic test_pause_over();
    game_state = PAUSE;
    repeat (3) pulse();
    checks++; if (score_bcd !== 16'h0102) begin errors++; $display("FAIL pause_frozen got=%h want=0102", score_bcd); end
    game_state = OVER;
    repeat (3) pulse();
    checks++; if (score_bcd !== 16'h0102) begin errors++; $display("FAIL over_frozen got=%h want=0102", score_bcd); end
    game_state = PLAY;
  endtask

  // Scan order, dwell time and leading-zero blanking for score 0042.
  task automatic test_display();
    do_reset();
    repeat (14) pulse();
    checks++; if (score_bcd !== 16'h0042) begin errors++; $display("FAIL disp_score got=%h want=0042", score_bcd); end
    for (int c = 0; c < 16; c++) begin
      checks++; if (an !== exp_an()) begin errors++; $display("FAIL disp_an cyc=%0d got=%b want=%b", c, an, exp_an()); end
      checks++; if (seg !== exp_seg()) begin errors++; $display("FAIL disp_seg cyc=%0d got=%h want=%h", c, seg, exp_seg()); end
      step();
    end
  endtask

  // High score lags the live score by one edge; restart clears the flag only.
  task automatic test_hiscore();
    do_reset();
    get_food = 1'b1;
    step();
    checks++; if (score_bcd !== 16'h0003) begin errors++; $display("FAIL hi_score_now got=%h want=0003", score_bcd); end
    checks++; if (hi_score_bcd !== 16'h0000) begin errors++; $display("FAIL hi_lag got=%h want=0000", hi_score_bcd); end
    get_food = 1'b0;
    step();
    checks++; if (hi_score_bcd !== (HI_EN ? 16'h0003 : 16'h0000)) begin errors++; $display("FAIL hi_follow got=%h want=%h", hi_score_bcd, HI_EN ? 16'h0003 : 16'h0000); end
    checks++; if (new_record !== HI_EN) begin errors++; $display("FAIL hi_new_record got=%b want=%b", new_record, HI_EN); end
    game_state = RESTART;
    step();
    checks++; if (score_bcd !== 16'h0000) begin errors++; $display("FAIL restart_score got=%h want=0000", score_bcd); end
    checks++; if (new_record !== 1'b0) begin errors++; $display("FAIL restart_record got=%b want=0", new_record); end
    checks++; if (hi_score_bcd !== (HI_EN ? 16'h0003 : 16'h0000)) begin errors++; $display("FAIL restart_hi got=%h want=%h", hi_score_bcd, HI_EN ? 16'h0003 : 16'h0000); end
    game_state = PLAY;
    show_hi = 1'b1;
    repeat (2) pulse();
    for (int c = 0; c < 8; c++) begin
      checks++; if (seg !== exp_seg()) begin errors++; $display("FAIL show_hi_seg cyc=%0d got=%h want=%h", c, seg, exp_seg()); end
      step();
    end
    checks++; if (hi_score_bcd !== to_bcd(m_hi)) begin errors++; $display("FAIL hi_model got=%h want=%h", hi_score_bcd, to_bcd(m_hi)); end
    checks++; if (new_record !== m_nr) begin errors++; $display("FAIL record_model got=%b want=%b", new_record, m_nr); end
    show_hi = 1'b0;
  endtask

  // Count up to 9999 and confirm a further food saturates instead of wrapping.
  task automatic test_saturation();
    int budget;
    do_reset();
    budget = 0;
    while (m_score != MAX_SCORE && budget < 4000) begin
      pulse();
      budget++;
    end
    checks++; if (score_bcd !== 16'h9999) begin errors++; $display("FAIL sat_reach got=%h want=9999", score_bcd); end
    pulse();
    checks++; if (score_bcd !== 16'h9999) begin errors++; $display("FAIL sat_hold got=%h want=9999", score_bcd); end
    step();
    checks++; if (hi_score_bcd !== (HI_EN ? 16'h9999 : 16'h0000)) begin errors++; $display("FAIL sat_hi got=%h want=%h", hi_score_bcd, HI_EN ? 16'h9999 : 16'h0000); end
  endtask

  // Random states, food and display selection, compared every cycle.
  task automatic test_random();
    int r;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      r = $urandom_range(0, 39);
      game_state = (r < 30) ? PLAY : (r < 34) ? PAUSE : (r < 38) ? OVER : RESTART;
      get_food = ($urandom_range(0, 2) == 0);
      if ((c % 50) == 0) show_hi = 1'($urandom_range(0, 1));
      step();
      checks++; if (score_bcd !== to_bcd(m_score)) begin errors++; $display("FAIL rnd_score cyc=%0d got=%h want=%h", c, score_bcd, to_bcd(m_score)); end
      checks++; if (hi_score_bcd !== to_bcd(m_hi)) begin errors++; $display("FAIL rnd_hi cyc=%0d got=%h want=%h", c, hi_score_bcd, to_bcd(m_hi)); end
      checks++; if (new_record !== m_nr) begin errors++; $display("FAIL rnd_record cyc=%0d got=%b want=%b", c, new_record, m_nr); end
      checks++; if (an !== exp_an()) begin errors++; $display("FAIL rnd_an cyc=%0d got=%b want=%b", c, an, exp_an()); end
      checks++; if (seg !== exp_seg()) begin errors++; $display("FAIL rnd_seg cyc=%0d got=%h want=%h", c, seg, exp_seg()); end
    end
  endtask

  initial begin
    rst = 1'b1;
    game_state = PLAY;
    get_food = 1'b0;
    show_hi = 1'b0;
    test_reset();
    test_food_edges();
    test_carry();
    test_pause_over();
    test_display();
    test_hiscore();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
